gtx_frame_rx: RTL and testbench
===============================

GTX_FRAME_RX -- requirements
Module: gtx_frame_rx

Interface
REQ-001 Parameter DATA_WIDTH, default 2: payload bits per frame, legal range 1..256.
REQ-002 Parameter LOCK_COUNT, default 4: consecutive good frames needed to assert lock, legal range 1..255.
REQ-003 Parameter ERR_LIMIT, default 4: consecutive bad frames that drop lock, legal range 1..255.
REQ-004 Port clk_i, input, 1: receive user clock; all logic is on its rising edge.
REQ-005 Port rst_n_i, input, 1: asynchronous active-low reset.
REQ-006 Port ctrl_i, input, 2: per-byte K-character flags; bit0 = data_i[7:0], bit1 = data_i[15:8].
REQ-007 Port data_i, input, 16: received word; one word is consumed every cycle.
REQ-008 Port data_o, output, DATA_WIDTH: last accepted payload.
REQ-009 Port valid_o, output, 1: one-cycle pulse when data_o updates.
REQ-010 Port locked_o, output, 1: link frame lock.
REQ-011 Port err_o, output, 1: one-cycle pulse per bad frame.
REQ-012 Port err_cnt_o, output, 16: saturating count of bad frames.

Function
REQ-013 W SHALL equal ceil(DATA_WIDTH/16), and a frame SHALL be 1 header word, then W payload words, then 1 checksum word.
REQ-014 Header: ctrl_i=2'b01, data_i[7:0]=8'hBC (K28.5), data_i[15:8]=8-bit sequence number.
REQ-015 Idle: ctrl_i=2'b11, data_i=16'hBCBC; idle SHALL be ignored in HUNT and SHALL count as a K-character error inside a frame.
REQ-016 Payload word i (i=0 first) SHALL carry payload bits [16i+15:16i]; bits above DATA_WIDTH-1 in the last word SHALL be discarded from data_o but included in the checksum.
REQ-017 Checksum word SHALL equal the sum mod 2^16 of the W payload words.
REQ-018 FSM states: HUNT, PAYLOAD, CHECK; reset state HUNT.
REQ-019 HUNT: on a header, capture seq, clear the word index and the running sum, and go to PAYLOAD; any other word stays in HUNT with no error.
REQ-020 PAYLOAD: on ctrl_i=00, store the word, add it to the sum, and increment the index; after the W-th word, go to CHECK.
REQ-021 CHECK: on ctrl_i=00, compare with the sum; go to HUNT after evaluation whether the result is good or bad.
REQ-022 A word with ctrl_i!=00 in PAYLOAD or CHECK SHALL abort the frame as bad; if that word is a header, the FSM SHALL restart PAYLOAD using its seq in the same cycle, otherwise go to HUNT.
REQ-023 Sequence check: once a previous good frame exists since lock loss or reset, seq SHALL equal previous seq+1 mod 256 (8'hFF->8'h00 legal), else the frame is bad; with no history, any seq is accepted.
REQ-024 Good frame = checksum match AND sequence pass; the good-run counter SHALL increment saturating at LOCK_COUNT, and the bad-run counter SHALL clear.
REQ-025 Bad frame SHALL pulse err_o, increment err_cnt_o (saturating at 16'hFFFF), increment the bad-run counter, and clear the good-run counter.
REQ-026 locked_o SHALL rise on the clock edge completing the LOCK_COUNT-th consecutive good frame.
REQ-027 locked_o SHALL fall on the edge completing the ERR_LIMIT-th consecutive bad frame, and sequence history SHALL be cleared at the same edge.
REQ-028 On a good frame with locked_o high after that edge (including the locking frame), data_o SHALL update and valid_o SHALL pulse on the same edge; latency SHALL be 1 cycle after the checksum word is sampled.
REQ-029 On a bad frame, or a good frame while unlocked, data_o SHALL hold and valid_o SHALL stay low.
REQ-030 valid_o and err_o SHALL never be high in the same cycle.

Reset
REQ-031 Asserting rst_n_i low SHALL immediately force state HUNT and set data_o=0, valid_o=0, locked_o=0, err_o=0, err_cnt_o=0; all counters, the sum and sequence history SHALL also clear.
REQ-032 Reset asserted mid-frame SHALL discard the partial frame, and the first frame after release SHALL be accepted with any seq.

Verification (DATA_WIDTH=32, LOCK_COUNT=4, ERR_LIMIT=4)
REQ-033 Four frames seq 0..3, payload 16'h5678, 16'h1234, checksum 16'h68AC, k=01/00/00/00 -> locked_o rises and valid_o pulses with data_o=32'h12345678 after frame 4 only.
REQ-034 While locked, a frame with checksum 16'h68AD -> err_o pulse, err_cnt_o=1, data_o holds, locked_o stays 1.
REQ-035 While locked, seq 5 follows seq 3 -> bad frame; then four consecutive bad frames -> locked_o falls on the 4th; the next good frame is accepted with any seq.
REQ-036 Header 16'h07BC (k=01) injected after payload word 0 -> err_o pulse, the frame restarts with seq 7, and a subsequent valid completion is accepted.
REQ-037 Seq wrap 8'hFF -> 8'h00 while locked -> good frame, valid_o pulses; idle 16'hBCBC/k=11 between frames -> no error.
REQ-038 rst_n_i pulsed low during a payload word -> all outputs 0 asynchronously; the next complete frame is counted good.

Source files
------------

// File: rtl/gtx_frame_rx.sv
// Frame receiver for a 16-bit GTX user interface: header/payload/checksum framing,
// sequence tracking, and lock acquisition/loss with error accounting.
module gtx_frame_rx #(
  parameter int DATA_WIDTH = 2,
  parameter int LOCK_COUNT = 4,
  parameter int ERR_LIMIT  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [1:0]            ctrl_i,
  input  logic [15:0]           data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  output logic                  locked_o,
  output logic                  err_o,
  output logic [15:0]           err_cnt_o
);

  localparam int W     = (DATA_WIDTH + 15) / 16;
  localparam int PW    = W * 16;
  localparam int IDX_W = (W > 1) ? $clog2(W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(W - 1);
  localparam logic [7:0] LOCK_MAX = 8'(LOCK_COUNT);
  localparam logic [7:0] ERR_MAX  = 8'(ERR_LIMIT);

  typedef enum logic [1:0] {HUNT, PAYLOAD, CHECK} state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [15:0]           sum_q, sum_d;
  logic [7:0]            seq_q, seq_d;
  logic [7:0]            prev_seq_q, prev_seq_d;
  logic                  hist_q, hist_d;
  logic [7:0]            good_run_q, good_run_d;
  logic [7:0]            bad_run_q, bad_run_d;
  logic [PW-1:0]         payload_q, payload_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;
  logic                  locked_q, locked_d;
  logic [15:0]           err_cnt_q, err_cnt_d;

  logic is_hdr, is_data, seq_ok, frame_good, frame_bad;

  assign is_hdr  = (ctrl_i == 2'b01) && (data_i[7:0] == 8'hBC);
  assign is_data = (ctrl_i == 2'b00);
  assign seq_ok  = !hist_q || (seq_q == prev_seq_q + 8'd1);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    sum_d      = sum_q;
    seq_d      = seq_q;
    payload_d  = payload_q;
    frame_good = 1'b0;
    frame_bad  = 1'b0;

    case (state_q)
      HUNT: begin
        if (is_hdr) begin
          seq_d   = data_i[15:8];
          idx_d   = '0;
          sum_d   = '0;
          state_d = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (is_data) begin
          payload_d[idx_q*16 +: 16] = data_i;
          sum_d = sum_q + data_i;
          idx_d = idx_q + 1'b1;
          if (idx_q == LAST_IDX) state_d = CHECK;
        end else begin
          frame_bad = 1'b1;
        end
      end
      CHECK: begin
        if (is_data) begin
          if ((data_i == sum_q) && seq_ok) frame_good = 1'b1;
          else                            frame_bad  = 1'b1;
          state_d = HUNT;
        end else begin
          frame_bad = 1'b1;
        end
      end
      default: state_d = HUNT;
    endcase

    // An aborting header immediately opens a fresh frame with its own seq.
    if ((state_q != HUNT) && !is_data) begin
      if (is_hdr) begin
        seq_d   = data_i[15:8];
        idx_d   = '0;
        sum_d   = '0;
        state_d = PAYLOAD;
      end else begin
        state_d = HUNT;
      end
    end
  end

  always_comb begin
    prev_seq_d = prev_seq_q;
    hist_d     = hist_q;
    good_run_d = good_run_q;
    bad_run_d  = bad_run_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    locked_d   = locked_q;
    err_cnt_d  = err_cnt_q;

    if (frame_good) begin
      bad_run_d  = '0;
      hist_d     = 1'b1;
      prev_seq_d = seq_q;
      if (good_run_q != LOCK_MAX) good_run_d = good_run_q + 8'd1;
      if (good_run_d == LOCK_MAX) locked_d = 1'b1;
      if (locked_d) begin
        valid_d = 1'b1;
        data_d  = payload_q[DATA_WIDTH-1:0];
      end
    end else if (frame_bad) begin
      err_d      = 1'b1;
      good_run_d = '0;
      if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
      if (bad_run_q != ERR_MAX)  bad_run_d = bad_run_q + 8'd1;
      if (bad_run_d == ERR_MAX) begin
        locked_d = 1'b0;
        hist_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= HUNT;
      idx_q      <= '0;
      sum_q      <= '0;
      seq_q      <= '0;
      prev_seq_q <= '0;
      hist_q     <= 1'b0;
      good_run_q <= '0;
      bad_run_q  <= '0;
      payload_q  <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      locked_q   <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      sum_q      <= sum_d;
      seq_q      <= seq_d;
      prev_seq_q <= prev_seq_d;
      hist_q     <= hist_d;
      good_run_q <= good_run_d;
      bad_run_q  <= bad_run_d;
      payload_q  <= payload_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      locked_q   <= locked_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign err_o     = err_q;
  assign locked_o  = locked_q;
  assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_gtx_frame_rx.sv
// Directed bench for gtx_frame_rx (DATA_WIDTH=32): expected valid/err events are
// queued as frames are sent and a negedge monitor pops and compares them.
module tb_gtx_frame_rx;

  logic        clk;
  logic        rst_n;
  logic [1:0]  ctrl;
  logic [15:0] data;
  logic [31:0] data_o;
  logic        valid_o, locked_o, err_o;
  logic [15:0] err_cnt_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_valid;
    logic [31:0] data;
    logic [15:0] cnt;
  } exp_t;
  exp_t exp_q[$];

  gtx_frame_rx #(.DATA_WIDTH(32), .LOCK_COUNT(4), .ERR_LIMIT(4)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .ctrl_i(ctrl), .data_i(data),
    .data_o(data_o), .valid_o(valid_o), .locked_o(locked_o),
    .err_o(err_o), .err_cnt_o(err_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end else begin
      $display("ok   %s = %h", name, act);
    end
  endtask

  task automatic push(input bit v, input logic [31:0] d, input logic [15:0] c);
    exp_t e;
    e.is_valid = v;
    e.data     = d;
    e.cnt      = c;
    exp_q.push_back(e);
  endtask

  task automatic word(input logic [1:0] k, input logic [15:0] d);
    @(negedge clk);
    ctrl = k;
    data = d;
  endtask

  task automatic idle();
    word(2'b11, 16'hBCBC);
  endtask

  task automatic frame(input logic [7:0] s, input logic [15:0] p0, input logic [15:0] p1,
                       input logic [15:0] c);
    word(2'b01, {s, 8'hBC});
    word(2'b00, p0);
    word(2'b00, p1);
    word(2'b00, c);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_data"},   data_o, 32'h0);
    chk({tag, "_valid"},  {31'b0, valid_o}, 32'h0);
    chk({tag, "_locked"}, {31'b0, locked_o}, 32'h0);
    chk({tag, "_err"},    {31'b0, err_o}, 32'h0);
    chk({tag, "_errcnt"}, {16'b0, err_cnt_o}, 32'h0);
  endtask

  always @(negedge clk) begin
    if (rst_n && (valid_o || err_o)) begin
      exp_t e;
      if (valid_o && err_o) chk("valid_err_overlap", 32'h1, 32'h0);
      if (exp_q.size() == 0) begin
        chk("unexpected_event", {30'b0, valid_o, err_o}, 32'h0);
      end else begin
        e = exp_q.pop_front();
        chk("event_is_valid", {31'b0, valid_o}, {31'b0, e.is_valid});
        chk("event_data", data_o, e.data);
        chk("event_errcnt", {16'b0, err_cnt_o}, {16'b0, e.cnt});
      end
    end
  end

  initial begin
    rst_n = 1'b1;
    ctrl  = 2'b11;
    data  = 16'hBCBC;
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("reset");
    @(negedge clk) rst_n = 1'b1;
    repeat (3) idle();

    // Acquire lock on four good frames; only the fourth produces data.
    for (int s = 0; s < 4; s++) begin
      if (s == 3) push(1'b1, 32'h12345678, 16'd0);
      frame(8'(s), 16'h5678, 16'h1234, 16'h68AC);
      idle();
      chk($sformatf("lock_after_frame%0d", s), {31'b0, locked_o}, (s == 3) ? 32'h1 : 32'h0);
    end

    // Bad checksum while locked.
    push(1'b0, 32'h12345678, 16'd1);
    frame(8'h04, 16'h5678, 16'h1234, 16'h68AD);
    idle();
    chk("lock_after_badsum", {31'b0, locked_o}, 32'h1);

    // Good frame seq 4 (prev good was 3), then a seq skip and three bad checksums.
    push(1'b1, 32'h00020001, 16'd1);
    frame(8'h04, 16'h0001, 16'h0002, 16'h0003);
    push(1'b0, 32'h00020001, 16'd2);
    frame(8'h06, 16'h0001, 16'h0002, 16'h0003);
    for (int b = 0; b < 3; b++) begin
      push(1'b0, 32'h00020001, 16'(3 + b));
      frame(8'h05, 16'h0001, 16'h0002, 16'h0009);
      idle();
      chk($sformatf("lock_after_bad%0d", b + 2), {31'b0, locked_o}, (b == 2) ? 32'h0 : 32'h1);
    end

    // History cleared: relock starting from an arbitrary seq.
    for (int s = 3; s < 7; s++) begin
      if (s == 6) push(1'b1, 32'h12345678, 16'd5);
      frame(8'(s), 16'h5678, 16'h1234, 16'h68AC);
    end
    idle();
    chk("relock", {31'b0, locked_o}, 32'h1);

    // Header injected after payload word 0 aborts and restarts with seq 7.
    push(1'b0, 32'h12345678, 16'd6);
    push(1'b1, 32'h5555AAAA, 16'd6);
    word(2'b01, 16'h07BC);
    word(2'b00, 16'h1111);
    word(2'b01, 16'h07BC);
    word(2'b00, 16'hAAAA);
    word(2'b00, 16'h5555);
    word(2'b00, 16'hFFFF);
    idle();
    chk("lock_after_restart", {31'b0, locked_o}, 32'h1);

    // Asynchronous reset in the middle of a payload word.
    word(2'b01, 16'h08BC);
    word(2'b00, 16'h1111);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("midreset");
    @(negedge clk) rst_n = 1'b1;
    idle();

    // Relock after reset on FC..FF (checksum wraps to 0), then wrap to 00 past idles.
    for (int s = 252; s < 256; s++) begin
      if (s == 255) push(1'b1, 32'h0001FFFF, 16'd0);
      frame(8'(s), 16'hFFFF, 16'h0001, 16'h0000);
    end
    repeat (3) idle();
    chk("lock_after_reset", {31'b0, locked_o}, 32'h1);
    push(1'b1, 32'h03040102, 16'd0);
    frame(8'h00, 16'h0102, 16'h0304, 16'h0406);
    repeat (3) idle();
    chk("lock_after_wrap", {31'b0, locked_o}, 32'h1);

    chk("events_outstanding", exp_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
